// File: rtl/can_pkg.sv
// Shared defaults and mask helpers for the CAN register bank.
package can_pkg;

  localparam int unsigned CAN_WIDTH = 8;
  localparam int unsigned CAN_DEPTH = 4;
  localparam int unsigned CAN_AW    = 2;
  localparam int unsigned CAN_MAX_W = 64;

  // Host writes may touch only bits that are writable and not sticky event bits.
  function automatic logic [CAN_MAX_W-1:0] host_wr_mask(input logic [CAN_MAX_W-1:0] wr_mask,
                                                        input logic [CAN_MAX_W-1:0] cor_mask);
    return wr_mask & ~cor_mask;
  endfunction

endpackage

// File: rtl/can_reg_cell.sv
// One register with reset value, host write mask and clear-on-read event bits.
module can_reg_cell
  import can_pkg::*;
#(
  parameter int unsigned      WIDTH    = CAN_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter logic [WIDTH-1:0] WR_MASK  = '1,
  parameter logic [WIDTH-1:0] COR_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_clr,
  input  logic [WIDTH-1:0] evt_set,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] HOST_MASK =
    WIDTH'(host_wr_mask(CAN_MAX_W'(WR_MASK), CAN_MAX_W'(COR_MASK)));

  logic [WIDTH-1:0] q_next;

  // Event set is applied last so it wins over a coincident clear-on-read.
  always_comb begin
    q_next = q;
    if (wr_en)
      q_next = (q & ~HOST_MASK) | (wr_data & HOST_MASK);
    if (rd_clr)
      q_next = q_next & ~COR_MASK;
    q_next = q_next | (evt_set & COR_MASK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= q_next;
  end

endmodule

// File: rtl/can_register_bank.sv
// Host-accessible register bank with masked writes, clear-on-read events and irq.
module can_register_bank
  import can_pkg::*;
#(
  parameter int unsigned              WIDTH    = CAN_WIDTH,
  parameter int unsigned              DEPTH    = CAN_DEPTH,
  parameter int unsigned              AW       = CAN_AW,
  parameter logic [DEPTH*WIDTH-1:0]   RST_VAL  = '0,
  parameter logic [DEPTH*WIDTH-1:0]   WR_MASK  = '1,
  parameter logic [DEPTH*WIDTH-1:0]   COR_MASK = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs,
  input  logic                     we,
  input  logic [AW-1:0]            addr,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     rd_valid,
  input  logic [DEPTH*WIDTH-1:0]   evt_set,
  output logic                     irq
);

  logic [WIDTH-1:0]       regs [DEPTH];
  logic [DEPTH*WIDTH-1:0] regs_flat;
  logic [WIDTH-1:0]       rd_mux;
  logic                   rd_req;

  assign rd_req = cs & ~we;

  // Out-of-range addresses match no cell, so writes there change nothing.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    can_reg_cell #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL[i*WIDTH +: WIDTH]),
      .WR_MASK (WR_MASK[i*WIDTH +: WIDTH]),
      .COR_MASK(COR_MASK[i*WIDTH +: WIDTH])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (cs & we & (addr == AW'(i))),
      .wr_data(data_in),
      .rd_clr (rd_req & (addr == AW'(i))),
      .evt_set(evt_set[i*WIDTH +: WIDTH]),
      .q      (regs[i])
    );
    assign regs_flat[i*WIDTH +: WIDTH] = regs[i];
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (addr == AW'(i)) rd_mux = regs[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) data_out <= rd_mux;
      irq      <= |(regs_flat & COR_MASK);
    end
  end

endmodule

// File: tb/tb_can_register_bank.sv
// Directed table-driven bench for can_register_bank (DEPTH=3, AW=2).
module tb_can_register_bank;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;
  localparam int unsigned A = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cs = 1'b0;
  logic             we = 1'b0;
  logic [A-1:0]     addr = '0;
  logic [W-1:0]     data_in = '0;
  logic [W-1:0]     data_out;
  logic             rd_valid;
  logic [D*W-1:0]   evt_set = '0;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  can_register_bank #(
    .WIDTH   (W),
    .DEPTH   (D),
    .AW      (A),
    .RST_VAL ({8'h00, 8'hA5, 8'h00}),
    .WR_MASK ({8'hFF, 8'hFF, 8'h0F}),
    .COR_MASK({8'h03, 8'h00, 8'h00})
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .evt_set (evt_set),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         cs;
    logic         we;
    logic [A-1:0] addr;
    logic [W-1:0] din;
    logic [D*W-1:0] evt;
    logic [W-1:0] exp_d;
    logic         exp_v;
    logic         exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic w, input logic [A-1:0] a, input logic [W-1:0] di,
                     input logic [D*W-1:0] ev, input logic [W-1:0] ed, input logic ev_v,
                     input logic ei);
    vec_t v;
    v.cs = c; v.we = w; v.addr = a; v.din = di; v.evt = ev;
    v.exp_d = ed; v.exp_v = ev_v; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] ed, input logic ev,
                            input logic ei);
    check({tag, " data_out"}, data_out, ed);
    check({tag, " rd_valid"}, W'(rd_valid), W'(ev));
    check({tag, " irq"}, W'(irq), W'(ei));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   cs   we   ad    din    evt          exp_d  v  irq
    add(1'b1, 1'b1, 2'd0, 8'hFF, 24'h000000, 8'h00, 0, 0); // masked write reg0
    add(1'b1, 1'b0, 2'd0, 8'h00, 24'h000000, 8'h0F, 1, 0);
    add(1'b0, 1'b0, 2'd0, 8'h00, 24'h000000, 8'h0F, 0, 0); // data_out holds
    add(1'b1, 1'b0, 2'd1, 8'h00, 24'h000000, 8'hA5, 1, 0);
    add(1'b1, 1'b1, 2'd1, 8'h3C, 24'h000000, 8'hA5, 0, 0);
    add(1'b1, 1'b1, 2'd2, 8'hFF, 24'h000000, 8'hA5, 0, 0); // COR bits not host-writable
    add(1'b1, 1'b0, 2'd2, 8'h00, 24'h000000, 8'hFC, 1, 0);
    add(1'b0, 1'b0, 2'd0, 8'h00, 24'h010000, 8'hFC, 0, 0); // event reg2 bit0
    add(1'b0, 1'b0, 2'd0, 8'h00, 24'h000000, 8'hFC, 0, 1);
    add(1'b1, 1'b0, 2'd2, 8'h00, 24'h000000, 8'hFD, 1, 1); // clear-on-read
    add(1'b0, 1'b0, 2'd0, 8'h00, 24'h000000, 8'hFD, 0, 0);
    add(1'b1, 1'b0, 2'd2, 8'h00, 24'h000000, 8'hFC, 1, 0);
    add(1'b0, 1'b0, 2'd0, 8'h00, 24'h010000, 8'hFC, 0, 0);
    add(1'b1, 1'b0, 2'd2, 8'h00, 24'h020000, 8'hFD, 1, 1); // collision on bit1
    add(1'b0, 1'b0, 2'd0, 8'h00, 24'h000000, 8'hFD, 0, 1);
    add(1'b1, 1'b0, 2'd2, 8'h00, 24'h000000, 8'hFE, 1, 1);
    add(1'b0, 1'b0, 2'd0, 8'h00, 24'h000000, 8'hFE, 0, 0);
    add(1'b1, 1'b1, 2'd3, 8'h55, 24'h000000, 8'hFE, 0, 0); // out of range
    add(1'b1, 1'b0, 2'd3, 8'h00, 24'h000000, 8'h00, 1, 0);
    add(1'b1, 1'b0, 2'd0, 8'h00, 24'h000000, 8'h0F, 1, 0); // streaming 0,1,2,0
    add(1'b1, 1'b0, 2'd1, 8'h00, 24'h000000, 8'h3C, 1, 0);
    add(1'b1, 1'b0, 2'd2, 8'h00, 24'h000000, 8'hFC, 1, 0);
    add(1'b1, 1'b0, 2'd0, 8'h00, 24'h000000, 8'h0F, 1, 0);
    add(1'b0, 1'b0, 2'd0, 8'h00, 24'h000000, 8'h0F, 0, 0);
    add(1'b0, 1'b0, 2'd0, 8'h00, 24'h00FFFF, 8'h0F, 0, 0); // events on non-COR bits ignored
    add(1'b1, 1'b0, 2'd0, 8'h00, 24'h000000, 8'h0F, 1, 0);
    add(1'b1, 1'b0, 2'd1, 8'h00, 24'h000000, 8'h3C, 1, 0);
    add(1'b0, 1'b0, 2'd0, 8'h00, 24'h000000, 8'h3C, 0, 0);

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2 check_outs("reset-async", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cs = vecs[i].cs; we = vecs[i].we; addr = vecs[i].addr;
      data_in = vecs[i].din; evt_set = vecs[i].evt;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_v, vecs[i].exp_irq);
    end

    // Reset mid-write with irq high: everything returns to reset values.
    cs = 1'b0; we = 1'b0; evt_set = 24'h010000;
    tick();
    evt_set = '0;
    tick();
    check("pre-reset irq", W'(irq), 8'h01);
    cs = 1'b1; we = 1'b1; addr = 2'd1; data_in = 8'h00; evt_set = 24'h020000;
    #2 rst = 1'b1;
    #1 check_outs("rst-mid-write", 8'h00, 1'b0, 1'b0);
    tick();
    check_outs("rst-held", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; cs = 1'b1; we = 1'b0; addr = 2'd1; evt_set = '0;
    tick();
    check_outs("post-rst reg1", 8'hA5, 1'b1, 1'b0);
    addr = 2'd2;
    tick();
    check_outs("post-rst reg2", 8'h00, 1'b1, 1'b0);
    addr = 2'd0;
    tick();
    check_outs("post-rst reg0", 8'h00, 1'b1, 1'b0);
    cs = 1'b0;
    tick();
    check_outs("post-rst idle", 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
